// File: rtl/hazard_control_unit.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: multi-cycle load-use stalls,
// taken-branch flush, data-memory wait and a saturating stall-cycle counter.
module hazard_control_unit #(
    parameter int         LOAD_USE_CYCLES = 1,
    parameter int         CNT_W           = 16,
    parameter logic [5:0] OP_RTYPE        = 6'b000000,
    parameter logic [5:0] OP_LW           = 6'b100011,
    parameter logic [5:0] OP_SW           = 6'b101011,
    parameter logic [5:0] OP_BEQ          = 6'b000100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_id_ir,
    input  logic [31:0]      id_ex_ir,
    input  logic             branch_taken,
    input  logic             mem_ready,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             if_id_write_enable,
    output logic             if_id_flush,
    output logic             id_ex_reset,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_count
);

    localparam int REM_W = (LOAD_USE_CYCLES < 2) ? 1 : $clog2(LOAD_USE_CYCLES + 1);
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_USE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01
    } state_t;

    state_t            state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [5:0] id_op, ex_op;
    logic [4:0] id_rs, id_rt, ex_dest;
    logic       id_reads_rt;
    logic       lu_hit;
    logic       stalling;

    logic       pc_write_int;
    logic       unused_ir_bits;

    assign id_op = if_id_ir[31:26];
    assign id_rs = if_id_ir[25:21];
    assign id_rt = if_id_ir[20:16];
    assign ex_op = id_ex_ir[31:26];

    // Destination of the ID/EX instruction comes purely from its opcode; nothing is latched.
    always_comb begin
        ex_dest = 5'd0;
        if (ex_op == OP_RTYPE) begin
            ex_dest = id_ex_ir[15:11];
        end else if (ex_op == OP_LW) begin
            ex_dest = id_ex_ir[20:16];
        end
    end

    assign id_reads_rt = (id_op == OP_RTYPE) || (id_op == OP_SW) || (id_op == OP_BEQ);

    assign lu_hit = (ex_op == OP_LW) && (ex_dest != 5'd0) &&
                    ((ex_dest == id_rs) || ((ex_dest == id_rt) && id_reads_rt));

    assign stalling = (state_q == ST_STALL) || lu_hit;

    assign unused_ir_bits = ^{if_id_ir[15:0], id_ex_ir[25:21], id_ex_ir[10:0]};

    always_comb begin
        state_d            = state_q;
        rem_d              = rem_q;
        pc_write_int       = 1'b1;
        if_id_write_enable = 1'b1;
        if_id_flush        = 1'b0;
        id_ex_reset        = 1'b1;
        pipe_hold          = 1'b0;

        if (!mem_ready) begin
            // Memory wait freezes the whole pipe and any pending load-use stall.
            pc_write_int       = 1'b0;
            if_id_write_enable = 1'b0;
            pipe_hold          = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_reset = 1'b0;
            state_d     = ST_RUN;
            rem_d       = '0;
        end else if (stalling) begin
            pc_write_int       = 1'b0;
            if_id_write_enable = 1'b0;
            id_ex_reset        = 1'b0;
            if (state_q == ST_STALL) begin
                rem_d = rem_q - 1'b1;
                if (rem_q <= REM_W'(1)) begin
                    state_d = ST_RUN;
                    rem_d   = '0;
                end
            end else if (LOAD_USE_CYCLES > 1) begin
                state_d = ST_STALL;
                rem_d   = REM_INIT;
            end
        end

        if (!rst_n) begin
            pc_write_int       = 1'b0;
            if_id_write_enable = 1'b0;
            if_id_flush        = 1'b0;
            id_ex_reset        = 1'b0;
            pipe_hold          = 1'b0;
        end
    end

    assign pc_write = pc_write_int;

    always_comb begin
        cnt_d = cnt_q;
        if (perf_clr) begin
            cnt_d = '0;
        end else if (!pc_write_int && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stall_count = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomised and directed bench for hazard_control_unit, running three parameterisations
// side by side against a per-instance behavioural model of the stall rules.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_id_ir, id_ex_ir;
    logic        branch_taken, mem_ready, perf_clr;

    logic [2:0]  pw, we, fl, ir_o, ph;
    logic [15:0] sc_a, sc_b;
    logic [3:0]  sc_c;

    always #5 clk = ~clk;

    hazard_control_unit #(.LOAD_USE_CYCLES(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst_n(rst_n), .if_id_ir(if_id_ir), .id_ex_ir(id_ex_ir),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .perf_clr(perf_clr),
        .pc_write(pw[0]), .if_id_write_enable(we[0]), .if_id_flush(fl[0]),
        .id_ex_reset(ir_o[0]), .pipe_hold(ph[0]), .stall_count(sc_a));

    hazard_control_unit #(.LOAD_USE_CYCLES(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rst_n(rst_n), .if_id_ir(if_id_ir), .id_ex_ir(id_ex_ir),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .perf_clr(perf_clr),
        .pc_write(pw[1]), .if_id_write_enable(we[1]), .if_id_flush(fl[1]),
        .id_ex_reset(ir_o[1]), .pipe_hold(ph[1]), .stall_count(sc_b));

    hazard_control_unit #(.LOAD_USE_CYCLES(3), .CNT_W(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .if_id_ir(if_id_ir), .id_ex_ir(id_ex_ir),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .perf_clr(perf_clr),
        .pc_write(pw[2]), .if_id_write_enable(we[2]), .if_id_flush(fl[2]),
        .id_ex_reset(ir_o[2]), .pipe_hold(ph[2]), .stall_count(sc_c));

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] LW_R2   = {6'b100011, 5'd1, 5'd2, 16'd0};
    localparam logic [31:0] LW_R0   = {6'b100011, 5'd1, 5'd0, 16'd0};
    localparam logic [31:0] ADD_R2  = {6'b000000, 5'd2, 5'd4, 5'd3, 5'd0, 6'b100000};
    localparam logic [31:0] ADD_R0  = {6'b000000, 5'd0, 5'd4, 5'd3, 5'd0, 6'b100000};
    localparam logic [31:0] ADDI_R2 = {6'b001000, 5'd5, 5'd2, 16'd1};

    // Model state: extra stall cycles still owed after the detecting cycle, and the counter.
    int lcyc[3] = '{1, 3, 3};
    int cmax[3] = '{65535, 65535, 15};
    int owed[3];
    int cnt_m[3];

    int n_vec  = 0;
    int n_fail = 0;

    function automatic bit m_hit();
        logic [5:0] ex_op, id_op;
        logic [4:0] dest;
        bit reads_rt;
        ex_op    = id_ex_ir[31:26];
        id_op    = if_id_ir[31:26];
        dest     = id_ex_ir[20:16];
        reads_rt = (id_op == 6'b000000) || (id_op == 6'b101011) || (id_op == 6'b000100);
        return (ex_op == 6'b100011) && (dest != 5'd0) &&
               ((dest == if_id_ir[25:21]) || (reads_rt && dest == if_id_ir[20:16]));
    endfunction

    // Expected {pc_write, if_id_write_enable, if_id_flush, id_ex_reset, pipe_hold}.
    function automatic logic [4:0] m_out(int k);
        if (!rst_n)                return 5'b00000;
        if (!mem_ready)            return 5'b00011;
        if (branch_taken)          return 5'b11100;
        if (owed[k] > 0 || m_hit()) return 5'b00000;
        return 5'b11010;
    endfunction

    function automatic int dut_cnt(int k);
        case (k)
            0:       return int'(sc_a);
            1:       return int'(sc_b);
            default: return int'(sc_c);
        endcase
    endfunction

    function automatic logic [4:0] dut_out(int k);
        return {pw[k], we[k], fl[k], ir_o[k], ph[k]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, $time, act, act, exp, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic [31:0] ifid, input logic [31:0] idex,
                         input logic br, input logic mr, input logic clr);
        @(negedge clk);
        rst_n        = rst;
        if_id_ir     = ifid;
        id_ex_ir     = idex;
        branch_taken = br;
        mem_ready    = mr;
        perf_clr     = clr;
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                owed[k]  = 0;
                cnt_m[k] = 0;
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("outs[%0d]", k), int'(dut_out(k)), int'(m_out(k)));
            check($sformatf("count[%0d]", k), dut_cnt(k), cnt_m[k]);
        end
    endtask

    task automatic tick();
        logic [4:0] o;
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                o = m_out(k);
                if (perf_clr)                         cnt_m[k] = 0;
                else if (!o[4] && cnt_m[k] < cmax[k]) cnt_m[k]++;
                if (!mem_ready)          ;
                else if (branch_taken)   owed[k] = 0;
                else if (owed[k] > 0)    owed[k]--;
                else if (m_hit())        owed[k] = lcyc[k] - 1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] ifid, input logic [31:0] idex,
                        input logic br, input logic mr, input logic clr);
        apply(rst, ifid, idex, br, mr, clr);
        tick();
    endtask

    task automatic clear_counts();
        step(1'b1, NOP, NOP, 1'b0, 1'b1, 1'b1);
    endtask

    function automatic logic [31:0] rnd_ir();
        logic [5:0] op;
        case ($urandom_range(0, 5))
            0:       op = 6'b000000;
            1:       op = 6'b100011;
            2:       op = 6'b101011;
            3:       op = 6'b000100;
            4:       op = 6'b001000;
            default: op = 6'($urandom);
        endcase
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
    endfunction

    initial begin
        rst_n = 1'b1; if_id_ir = NOP; id_ex_ir = NOP;
        branch_taken = 1'b0; mem_ready = 1'b1; perf_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin owed[k] = 0; cnt_m[k] = 0; end
        #2 rst_n = 1'b0;

        apply(1'b0, NOP, NOP, 1'b0, 1'b1, 1'b0);
        check("reset_pc_write", int'(pw[1]), 0);
        check("reset_id_ex_reset", int'(ir_o[0]), 0);
        tick();
        step(1'b1, NOP, NOP, 1'b0, 1'b1, 1'b0);

        // Single- and triple-cycle load-use stall on LW r2 / ADD r3,r2,r4.
        clear_counts();
        apply(1'b1, ADD_R2, LW_R2, 1'b0, 1'b1, 1'b0);
        check("lu1_pc_write", int'(pw[0]), 0);
        check("lu1_id_ex_reset", int'(ir_o[0]), 0);
        tick();
        apply(1'b1, ADD_R2, NOP, 1'b0, 1'b1, 1'b0);
        check("lu1_resume", int'(pw[0]), 1);
        check("lu3_still", int'(pw[1]), 0);
        tick();
        step(1'b1, ADD_R2, NOP, 1'b0, 1'b1, 1'b0);
        apply(1'b1, ADD_R2, NOP, 1'b0, 1'b1, 1'b0);
        check("lu3_resume", int'(pw[1]), 1);
        tick();
        apply(1'b1, NOP, NOP, 1'b0, 1'b1, 1'b0);
        check("lu1_count", int'(sc_a), 1);
        check("lu3_count", int'(sc_b), 3);
        tick();

        // No stall for r0 destination or rt not read.
        clear_counts();
        step(1'b1, ADD_R0, LW_R0, 1'b0, 1'b1, 1'b0);
        step(1'b1, ADDI_R2, LW_R2, 1'b0, 1'b1, 1'b0);
        apply(1'b1, NOP, NOP, 1'b0, 1'b1, 1'b0);
        check("nofalse_count1", int'(sc_a), 0);
        check("nofalse_count3", int'(sc_b), 0);
        tick();

        // Branch in the second stall cycle.
        clear_counts();
        step(1'b1, ADD_R2, LW_R2, 1'b0, 1'b1, 1'b0);
        apply(1'b1, ADD_R2, NOP, 1'b1, 1'b1, 1'b0);
        check("br_pc_write", int'(pw[1]), 1);
        check("br_flush", int'(fl[1]), 1);
        check("br_id_ex_reset", int'(ir_o[1]), 0);
        tick();
        apply(1'b1, ADD_R2, NOP, 1'b0, 1'b1, 1'b0);
        check("br_run", int'(pw[1]), 1);
        check("br_count", int'(sc_b), 1);
        tick();

        // Memory wait in the second stall cycle.
        clear_counts();
        step(1'b1, ADD_R2, LW_R2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, ADD_R2, NOP, 1'b0, 1'b0, 1'b0);
            check("mw_hold", int'(ph[1]), 1);
            tick();
        end
        step(1'b1, ADD_R2, NOP, 1'b0, 1'b1, 1'b0);
        step(1'b1, ADD_R2, NOP, 1'b0, 1'b1, 1'b0);
        apply(1'b1, ADD_R2, NOP, 1'b0, 1'b1, 1'b0);
        check("mw_resume", int'(pw[1]), 1);
        check("mw_count", int'(sc_b), 7);
        tick();

        // Asynchronous reset mid-stall.
        clear_counts();
        step(1'b1, ADD_R2, LW_R2, 1'b0, 1'b1, 1'b0);
        apply(1'b0, ADD_R2, NOP, 1'b0, 1'b1, 1'b0);
        check("arst_pc_write", int'(pw[1]), 0);
        check("arst_hold", int'(ph[1]), 0);
        check("arst_count", int'(sc_b), 0);
        tick();
        apply(1'b1, ADD_R2, NOP, 1'b0, 1'b1, 1'b0);
        check("arst_run", int'(pw[1]), 1);
        check("arst_count_after", int'(sc_b), 0);
        tick();

        // Saturation of a 4-bit counter and clear priority.
        clear_counts();
        for (int i = 0; i < 20; i++) step(1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0);
        apply(1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0);
        check("sat_count4", int'(sc_c), 15);
        check("sat_count16", int'(sc_a), 20);
        tick();
        apply(1'b1, NOP, NOP, 1'b0, 1'b0, 1'b1);
        check("sat_held", int'(sc_c), 15);
        tick();
        apply(1'b1, NOP, NOP, 1'b0, 1'b1, 1'b0);
        check("sat_clr", int'(sc_c), 0);
        tick();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0), rnd_ir(), rnd_ir(),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) != 0),
                 ($urandom_range(0, 29) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
